// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Moore control FSM for the multicycle MIPS datapath, with
//           parametrised memory wait states.
// Rev     : 1.0
// ============================================================================
module multicycle_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output logic [1:0] i_or_d,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_control,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       memory_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [2:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       alu_out_write,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_FETCH   = 4'd1,
        S_IR_LOAD = 4'd2,
        S_DECODE  = 4'd3,
        S_EXEC_R  = 4'd4,
        S_WB_R    = 4'd5,
        S_EXEC_I  = 4'd6,
        S_WB_I    = 4'd7,
        S_ADDR    = 4'd8,
        S_MEM_RD  = 4'd9,
        S_WB_LW   = 4'd10,
        S_MEM_WR  = 4'd11,
        S_BRANCH  = 4'd12,
        S_JUMP    = 4'd13,
        S_ILLEGAL = 4'd14,
        S_UNUSED  = 4'd15
    } state_t;

    localparam logic [3:0] c_wait_load = 4'(MEM_WAIT - 1);
    localparam logic [5:0] c_op_rtype  = 6'b000000;
    localparam logic [5:0] c_op_addi   = 6'b001000;
    localparam logic [5:0] c_op_lw     = 6'b100011;
    localparam logic [5:0] c_op_sw     = 6'b101011;
    localparam logic [5:0] c_op_beq    = 6'b000100;
    localparam logic [5:0] c_op_bne    = 6'b000101;
    localparam logic [5:0] c_op_j      = 6'b000010;
    localparam logic [5:0] c_fn_add    = 6'b100000;
    localparam logic [5:0] c_fn_sub    = 6'b100010;
    localparam logic [5:0] c_fn_and    = 6'b100100;

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic [2:0] rop_q, rop_d;
    logic       bne_q, bne_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RST;
            wait_q  <= 4'd0;
            rop_q   <= 3'b001;
            bne_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rop_q   <= rop_d;
            bne_q   <= bne_d;
        end
    end

    // R-type ALU function and branch polarity are captured at DECODE so
    // that every output stays a function of registered state only.
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        rop_d         = rop_q;
        bne_d         = bne_q;
        i_or_d        = 2'b00;
        pc_source     = 2'b00;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_control    = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        memory_write  = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 3'b000;
        alu_out_write = 1'b0;
        illegal_op    = 1'b0;

        case (state_q)
            S_RST: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'b111;
                reg_dst    = 2'b10;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                alu_src_b = 2'b01;
                alu_op    = 3'b001;
                if (wait_q == 4'd0) state_d = S_IR_LOAD;
                else                wait_d  = wait_q - 4'd1;
            end
            S_IR_LOAD: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b001;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b     = 2'b11;
                alu_op        = 3'b001;
                alu_out_write = 1'b1;
                bne_d         = op_code[0];
                case (op_code)
                    c_op_rtype: begin
                        state_d = S_EXEC_R;
                        case (funct)
                            c_fn_add: rop_d = 3'b001;
                            c_fn_sub: rop_d = 3'b010;
                            c_fn_and: rop_d = 3'b011;
                            default:  state_d = S_ILLEGAL;
                        endcase
                    end
                    c_op_addi:          state_d = S_EXEC_I;
                    c_op_lw, c_op_sw:   state_d = S_ADDR;
                    c_op_beq, c_op_bne: state_d = S_BRANCH;
                    c_op_j:             state_d = S_JUMP;
                    default:            state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a     = 1'b1;
                alu_op        = rop_q;
                alu_out_write = 1'b1;
                state_d       = S_WB_R;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
                state_d   = S_FETCH;
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a     = 1'b1;
                alu_src_b     = 2'b10;
                alu_op        = 3'b001;
                alu_out_write = 1'b1;
                if (state_q == S_EXEC_I)    state_d = S_WB_I;
                else if (op_code == c_op_lw) state_d = S_MEM_RD;
                else                         state_d = S_MEM_WR;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_RD: begin
                i_or_d = 2'b01;
                if (wait_q == 4'd0) begin
                    mdr_write = 1'b1;
                    state_d   = S_WB_LW;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_WB_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 3'b001;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                i_or_d       = 2'b01;
                memory_write = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 3'b010;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                pc_control    = bne_q;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal_op = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Both memory-wait states start their countdown on entry.
        if ((state_d == S_FETCH && state_q != S_FETCH) ||
            (state_d == S_MEM_RD && state_q != S_MEM_RD))
            wait_d = c_wait_load;
    end

    assign state_dbg = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Self-checking bench; MEM_WAIT=1,2,3 instances against a path model.
// Rev     : 1.0
// ============================================================================
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [1:0] i_or_d;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_control;
        logic       ir_write;
        logic       mdr_write;
        logic       memory_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [2:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       illegal_op;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        int         cyc_w2;
        bit         illegal;
        string      name;
    } vec_t;

    typedef struct {
        logic [3:0] st;
        bit         last;
    } ent_t;

    localparam int NV = 11;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic [5:0] op_code = 6'd0;
    logic [5:0] funct   = 6'd0;
    wire [23:0] ov [3];
    wire [3:0]  sv [3];

    int   n_chk = 0;
    int   n_pass = 0;
    out_t base [16];
    ent_t pth  [3][64];
    int   plen [3];
    int   pos  [3];
    vec_t vecs [NV];
    int   add_seq [7];
    int   lw_seq  [11];
    int   lw_mdr  [11];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_ctrl #(.MEM_WAIT(g + 1)) u_dut (
            .clock        (clock),
            .reset        (reset),
            .op_code      (op_code),
            .funct        (funct),
            .i_or_d       (ov[g][23:22]),
            .pc_source    (ov[g][21:20]),
            .pc_write     (ov[g][19]),
            .pc_write_cond(ov[g][18]),
            .pc_control   (ov[g][17]),
            .ir_write     (ov[g][16]),
            .mdr_write    (ov[g][15]),
            .memory_write (ov[g][14]),
            .reg_write    (ov[g][13]),
            .reg_dst      (ov[g][12:11]),
            .mem_to_reg   (ov[g][10:8]),
            .alu_src_a    (ov[g][7]),
            .alu_src_b    (ov[g][6:5]),
            .alu_op       (ov[g][4:2]),
            .alu_out_write(ov[g][1]),
            .illegal_op   (ov[g][0]),
            .state_dbg    (sv[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic add_ent(input int d, input int st, input bit last);
        pth[d][plen[d]].st   = 4'(st);
        pth[d][plen[d]].last = last;
        plen[d]++;
    endtask

    // Instruction walk for the current op_code/funct, FETCH to last state.
    task automatic build_paths();
        int w;
        for (int d = 0; d < 3; d++) begin
            w = d + 1;
            plen[d] = 0;
            for (int k = 0; k < w; k++) add_ent(d, 1, 1'b0);
            add_ent(d, 2, 1'b0);
            add_ent(d, 3, 1'b0);
            case (op_code)
                6'h00: begin
                    if (funct == 6'h20 || funct == 6'h22 || funct == 6'h24) begin
                        add_ent(d, 4, 1'b0);
                        add_ent(d, 5, 1'b0);
                    end else begin
                        add_ent(d, 14, 1'b0);
                    end
                end
                6'h08: begin add_ent(d, 6, 1'b0); add_ent(d, 7, 1'b0); end
                6'h23: begin
                    add_ent(d, 8, 1'b0);
                    for (int k = 0; k < w; k++) add_ent(d, 9, k == w - 1);
                    add_ent(d, 10, 1'b0);
                end
                6'h2B: begin add_ent(d, 8, 1'b0); add_ent(d, 11, 1'b0); end
                6'h04, 6'h05: add_ent(d, 12, 1'b0);
                6'h02: add_ent(d, 13, 1'b0);
                default: add_ent(d, 14, 1'b0);
            endcase
        end
    endtask

    function automatic out_t exp_out(ent_t e);
        out_t o;
        o = base[e.st];
        if (e.st == 4'd4) begin
            case (funct)
                6'h20: o.alu_op = 3'b001;
                6'h22: o.alu_op = 3'b010;
                6'h24: o.alu_op = 3'b011;
                default: o.alu_op = 3'b000;
            endcase
        end
        if (e.st == 4'd12) o.pc_control = op_code[0];
        if (e.st == 4'd9)  o.mdr_write  = e.last;
        return o;
    endfunction

    task automatic tick();
        ent_t e;
        @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            if (reset) pos[d] = -1;
            else begin
                pos[d] = pos[d] + 1;
                if (pos[d] >= plen[d]) pos[d] = 0;
            end
            if (pos[d] < 0) begin
                e.st = 4'd0;
                e.last = 1'b0;
            end else begin
                e = pth[d][pos[d]];
            end
            chk($sformatf("state_w%0d", d + 1), 32'(sv[d]), 32'(e.st));
            chk($sformatf("outs_w%0d", d + 1), 32'(ov[d]), 32'(exp_out(e)));
        end
    endtask

    task automatic start(input logic [5:0] op, input logic [5:0] fn, input int rst_cycles);
        op_code = op;
        funct   = fn;
        build_paths();
        reset = 1'b1;
        repeat (rst_cycles) tick();
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        out_t o;
        int   t, cyc, ill_cnt, prev, found, rat, len, k;
        logic [5:0] rop, rfn;

        for (int i = 0; i < 16; i++) base[i] = '0;
        base[0].reg_write = 1'b1;  base[0].mem_to_reg = 3'b111; base[0].reg_dst = 2'b10;
        base[1].alu_src_b = 2'b01; base[1].alu_op = 3'b001;
        base[2].ir_write = 1'b1;   base[2].pc_write = 1'b1;
        base[2].alu_src_b = 2'b01; base[2].alu_op = 3'b001;
        base[3].alu_src_b = 2'b11; base[3].alu_op = 3'b001; base[3].alu_out_write = 1'b1;
        base[4].alu_src_a = 1'b1;  base[4].alu_out_write = 1'b1;
        base[5].reg_write = 1'b1;  base[5].reg_dst = 2'b01;
        base[6].alu_src_a = 1'b1;  base[6].alu_src_b = 2'b10;
        base[6].alu_op = 3'b001;   base[6].alu_out_write = 1'b1;
        base[7].reg_write = 1'b1;
        base[8] = base[6];
        base[9].i_or_d = 2'b01;
        base[10].reg_write = 1'b1; base[10].mem_to_reg = 3'b001;
        base[11].i_or_d = 2'b01;   base[11].memory_write = 1'b1;
        base[12].alu_src_a = 1'b1; base[12].alu_op = 3'b010;
        base[12].pc_write_cond = 1'b1; base[12].pc_source = 2'b01;
        base[13].pc_write = 1'b1;  base[13].pc_source = 2'b10;
        base[14].illegal_op = 1'b1;

        vecs[0]  = '{6'h00, 6'h20, 6, 1'b0, "add"};
        vecs[1]  = '{6'h00, 6'h22, 6, 1'b0, "sub"};
        vecs[2]  = '{6'h00, 6'h24, 6, 1'b0, "and"};
        vecs[3]  = '{6'h08, 6'h15, 6, 1'b0, "addi"};
        vecs[4]  = '{6'h23, 6'h3A, 8, 1'b0, "lw"};
        vecs[5]  = '{6'h2B, 6'h20, 6, 1'b0, "sw"};
        vecs[6]  = '{6'h04, 6'h22, 5, 1'b0, "beq"};
        vecs[7]  = '{6'h05, 6'h00, 5, 1'b0, "bne"};
        vecs[8]  = '{6'h02, 6'h24, 5, 1'b0, "j"};
        vecs[9]  = '{6'h3F, 6'h20, 5, 1'b1, "bad_op"};
        vecs[10] = '{6'h00, 6'h00, 5, 1'b1, "bad_funct"};

        add_seq = '{1, 1, 2, 3, 4, 5, 1};
        lw_seq  = '{1, 1, 1, 2, 3, 8, 9, 9, 9, 10, 1};
        lw_mdr  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        for (int d = 0; d < 3; d++) begin
            pos[d]  = -1;
            plen[d] = 1;
        end

        // Reset held three cycles.
        op_code = 6'h00;
        funct   = 6'h20;
        build_paths();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            o = ov[1];
            chk("rst_state", 32'(sv[1]), 32'd0);
            chk("rst_reg_write", 32'(o.reg_write), 32'd1);
            chk("rst_mem_to_reg", 32'(o.mem_to_reg), 32'd7);
            chk("rst_reg_dst", 32'(o.reg_dst), 32'd2);
        end
        reset = 1'b0;

        // add with MEM_WAIT=2.
        for (int i = 0; i < 7; i++) begin
            tick();
            o = ov[1];
            chk("add_seq", 32'(sv[1]), 32'(add_seq[i]));
            chk("add_reg_write", 32'(o.reg_write), 32'(add_seq[i] == 5));
            if (add_seq[i] == 5) chk("add_reg_dst", 32'(o.reg_dst), 32'd1);
            if (add_seq[i] == 4) chk("add_alu_op", 32'(o.alu_op), 32'd1);
        end

        // lw with MEM_WAIT=3.
        start(6'h23, 6'h00, 2);
        for (int i = 0; i < 11; i++) begin
            tick();
            o = ov[2];
            chk("lw_seq", 32'(sv[2]), 32'(lw_seq[i]));
            chk("lw_mdr", 32'(o.mdr_write), 32'(lw_mdr[i]));
            if (lw_seq[i] == 10) chk("lw_mem_to_reg", 32'(o.mem_to_reg), 32'd1);
        end

        // Vector table: FETCH-to-FETCH length and illegal pulse count (MEM_WAIT=2).
        for (int i = 0; i < NV; i++) begin
            start(vecs[i].op, vecs[i].fn, 2);
            cyc = -1;
            ill_cnt = 0;
            prev = 0;
            found = 0;
            for (t = 1; t <= 40 && found == 0; t++) begin
                tick();
                o = ov[1];
                if (o.illegal_op) ill_cnt++;
                if (t > 1 && sv[1] == 4'd1 && prev != 1) begin
                    cyc = t - 1;
                    found = 1;
                end
                prev = int'(sv[1]);
            end
            chk({"cycles_", vecs[i].name}, 32'(cyc), 32'(vecs[i].cyc_w2));
            chk({"illegal_cnt_", vecs[i].name}, 32'(ill_cnt), 32'(vecs[i].illegal));
        end

        // Reset during the first MEM_RD cycle of lw (MEM_WAIT=3).
        start(6'h23, 6'h00, 1);
        found = 0;
        for (t = 0; t < 30 && found == 0; t++) begin
            tick();
            if (sv[2] == 4'd9) found = 1;
        end
        chk("lw_reach_memrd", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        o = ov[2];
        chk("lw_abort_state", 32'(sv[2]), 32'd0);
        chk("lw_abort_mdr", 32'(o.mdr_write), 32'd0);
        reset = 1'b0;
        tick();
        chk("lw_restart", 32'(sv[2]), 32'd1);
        repeat (12) tick();

        // Reset during ADDR of sw (MEM_WAIT=3).
        start(6'h2B, 6'h00, 1);
        found = 0;
        for (t = 0; t < 30 && found == 0; t++) begin
            tick();
            if (sv[2] == 4'd8) found = 1;
        end
        chk("sw_reach_addr", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        o = ov[2];
        chk("sw_abort_state", 32'(sv[2]), 32'd0);
        chk("sw_abort_memwr", 32'(o.memory_write), 32'd0);
        reset = 1'b0;
        tick();
        chk("sw_restart", 32'(sv[2]), 32'd1);
        repeat (10) tick();

        // Random episodes with occasional mid-instruction reset.
        for (int e = 0; e < 80; e++) begin
            if ($urandom_range(0, 9) < 7) begin
                k = $urandom_range(0, NV - 1);
                rop = vecs[k].op;
                rfn = vecs[k].fn;
            end else begin
                rop = 6'($urandom);
                rfn = 6'($urandom);
            end
            start(rop, rfn, $urandom_range(1, 2));
            len = $urandom_range(5, 35);
            rat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
            for (int c = 0; c < len; c++) begin
                if (c == rat) reset = 1'b1;
                tick();
                reset = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
